sonar_trigger_gen: RTL
======================

SONAR_TRIGGER_GEN -- requirements
Module: sonar_trigger_gen

Interface
REQ-001 Parameter TRIGGER_CYCLES, default 500: trigger pulse width in clock cycles (10 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 3_000_000: maximum wait from end of trigger to measurement completion (60 ms).
REQ-003 Parameter HOLDOFF_CYCLES, default 3_000_000: minimum idle gap after a measurement, used only with SONAR_HOLDOFF_EN.
REQ-004 clock  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 medir  input  1  start request; sampled only in state inicial.
REQ-007 echo  input  1  raw HC-SR04 echo, asynchronous to clock.
REQ-008 medida_pronto  input  1  completion pulse from the downstream echo-width counter.
REQ-009 trigger  output  1  trigger to sensor.
REQ-010 pulso  output  1  synchronized echo, drives the downstream counter's pulso input.
REQ-011 pronto  output  1  one-cycle pulse: valid measurement finished.
REQ-012 timeout  output  1  one-cycle pulse: measurement aborted.
REQ-013 db_estado  output  3  current state code.

Function
REQ-014 Echo SHALL pass through a 2-flop synchronizer; pulso equals its second flop, independent of state (2-cycle latency).
REQ-015 States and db_estado codes SHALL be: inicial 000, dispara 001, espera_echo 010, medindo 011, final 100, erro 101, holdoff 110; unused codes return to inicial.
REQ-016 inicial: medir=1 -> dispara; otherwise stay; medir in any other state SHALL be ignored.
REQ-017 dispara: trigger=1 for exactly TRIGGER_CYCLES cycles, first high cycle is the cycle after medir sampled; then espera_echo.
REQ-018 A single timer SHALL clear on entering espera_echo and increment each cycle through espera_echo and medindo.
REQ-019 espera_echo: pulso=1 -> medindo; timer reaching TIMEOUT_CYCLES-1 -> erro.
REQ-020 medindo: medida_pronto=1 -> final; timer reaching TIMEOUT_CYCLES-1 -> erro.
REQ-021 Simultaneous event and timeout SHALL favour the event (pulso, medida_pronto).
REQ-022 final: pronto=1 for one cycle; erro: timeout=1 for one cycle; both then go to holdoff (macro defined) or inicial.
REQ-023 trigger, pronto, timeout SHALL be Moore outputs decoded from state only.
REQ-024 Timer width SHALL cover max(TIMEOUT_CYCLES, HOLDOFF_CYCLES, TRIGGER_CYCLES) without wrap; timer never wraps.
REQ-025 medir held high SHALL start a new measurement each time inicial is reached.

Reset
REQ-026 reset=1 at a rising edge SHALL force state inicial, timer 0, synchronizer flops 0.
REQ-027 Outputs after reset: trigger 0, pulso 0, pronto 0, timeout 0, db_estado 000.
REQ-028 Reset mid-operation (including mid-trigger) SHALL drop trigger on the next cycle, no pronto/timeout pulse.

Configuration
REQ-029 Macro SONAR_HOLDOFF_EN defined: final/erro -> holdoff, stay HOLDOFF_CYCLES cycles, then inicial; medir ignored in holdoff.
REQ-030 SONAR_HOLDOFF_EN undefined: holdoff state and its counting logic absent; final/erro -> inicial directly; code 110 unreachable.

Verification (TRIGGER_CYCLES=5, TIMEOUT_CYCLES=50, HOLDOFF_CYCLES=20)
REQ-031 Reset, medir pulse at cycle 10 -> trigger high cycles 11-15 exactly, db_estado 001 then 010.
REQ-032 echo high 30 cycles after trigger, medida_pronto 3 cycles after echo falls -> pulso mirrors echo delayed 2, pronto one cycle, timeout never.
REQ-033 echo never rises -> timeout one cycle, exactly 50 cycles after entering espera_echo, pronto never.
REQ-034 echo stuck high, no medida_pronto -> timeout after 50 cycles from espera_echo entry; medida_pronto and timeout same cycle -> pronto only.
REQ-035 reset asserted during cycle 3 of trigger -> trigger 0 next cycle, db_estado 000, no pronto/timeout.
REQ-036 With SONAR_HOLDOFF_EN, medir held high -> successive triggers at least 20 cycles after each pronto/timeout; without macro, next trigger begins 2 cycles after pronto.

Source files
------------

// File: rtl/sonar_trigger_gen.sv
// HC-SR04 trigger/echo sequencer: fires the trigger pulse, waits for the echo and the downstream width count.
// Optional post-measurement holdoff is compiled in with `define SONAR_HOLDOFF_EN.
module sonar_trigger_gen #(
  parameter int TRIGGER_CYCLES = 500,
  parameter int TIMEOUT_CYCLES = 3_000_000,
  parameter int HOLDOFF_CYCLES = 3_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       echo,
  input  logic       medida_pronto,
  output logic       trigger,
  output logic       pulso,
  output logic       pronto,
  output logic       timeout,
  output logic [2:0] db_estado
);

  localparam int MAX_A   = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int MAX_CYC = (MAX_A > TRIGGER_CYCLES) ? MAX_A : TRIGGER_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIGGER_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
`ifdef SONAR_HOLDOFF_EN
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_INICIAL     = 3'b000,
    S_DISPARA     = 3'b001,
    S_ESPERA_ECHO = 3'b010,
    S_MEDINDO     = 3'b011,
    S_FINAL       = 3'b100,
    S_ERRO        = 3'b101,
    S_HOLDOFF     = 3'b110
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic            r_echo_meta;
  logic            r_echo_sync;
  logic            w_timer_expired;

  // Saturating compare keeps the timer from ever wrapping, even if an event lands on the last count.
  assign w_timer_expired = (r_timer >= TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_INICIAL;
      r_timer     <= '0;
      r_echo_meta <= 1'b0;
      r_echo_sync <= 1'b0;
    end else begin
      r_echo_meta <= echo;
      r_echo_sync <= r_echo_meta;

      case (r_state)
        S_INICIAL: begin
          r_timer <= '0;
          if (medir) r_state <= S_DISPARA;
        end

        S_DISPARA: begin
          if (r_timer == TRIG_LAST) begin
            r_state <= S_ESPERA_ECHO;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_ESPERA_ECHO: begin
          if (!w_timer_expired) r_timer <= r_timer + 1'b1;
          if (r_echo_sync)          r_state <= S_MEDINDO;
          else if (w_timer_expired) r_state <= S_ERRO;
        end

        S_MEDINDO: begin
          if (!w_timer_expired) r_timer <= r_timer + 1'b1;
          if (medida_pronto)        r_state <= S_FINAL;
          else if (w_timer_expired) r_state <= S_ERRO;
        end

        S_FINAL, S_ERRO: begin
          r_timer <= '0;
`ifdef SONAR_HOLDOFF_EN
          r_state <= S_HOLDOFF;
`else
          r_state <= S_INICIAL;
`endif
        end

`ifdef SONAR_HOLDOFF_EN
        S_HOLDOFF: begin
          if (r_timer == HOLD_LAST) begin
            r_state <= S_INICIAL;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif

        default: begin
          r_state <= S_INICIAL;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign trigger   = (r_state == S_DISPARA);
  assign pronto    = (r_state == S_FINAL);
  assign timeout   = (r_state == S_ERRO);
  assign pulso     = r_echo_sync;
  assign db_estado = r_state;

endmodule
